// File: rtl/ts_pkg.sv
// ts_pkg - shared constants for the TS-over-USB path.
//   TS_PKT_LEN   : MPEG-TS packet length in bytes
//   TS_SYNC_BYTE : TS sync byte carried on the first byte of each packet
//   EP_ADDR_W    : EP3 buffer address width (also width of length fields)
//   ST_*         : ts_ep3_commit_ctrl state encodings
package ts_pkg;
   localparam int unsigned TS_PKT_LEN   = 188;
   localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
   localparam int unsigned EP_ADDR_W    = 11;

   localparam logic [2:0] ST_WAIT_RDY    = 3'd0;
   localparam logic [2:0] ST_CALC        = 3'd1;
   localparam logic [2:0] ST_FILL        = 3'd2;
   localparam logic [2:0] ST_COMMIT      = 3'd3;
   localparam logic [2:0] ST_WAIT_ACK_LO = 3'd4;
endpackage

// File: rtl/ts_len_align.sv
// ts_len_align - rounds a byte limit down to a whole number of packets.
//   clk, reset_n : clock, synchronous active-low reset
//   start        : one-cycle pulse, captures lim and starts the computation
//   lim          : requested length; values below PKT_LEN are treated as PKT_LEN
//   done         : one-cycle pulse when eff_len is valid
//   eff_len      : floor(max(lim,PKT_LEN)/PKT_LEN)*PKT_LEN, held until next start
module ts_len_align
   import ts_pkg::*;
#(
   parameter int unsigned PKT_LEN = TS_PKT_LEN,
   parameter int unsigned ADDR_W  = EP_ADDR_W
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] lim,
   output logic              done,
   output logic [ADDR_W-1:0] eff_len
);
   localparam logic [ADDR_W-1:0] PKT_A = ADDR_W'(PKT_LEN);

   logic [ADDR_W-1:0] rem;
   logic              busy;

   // One packet subtracted per cycle; a full 11-bit limit needs 10
   // subtractions plus the final compare.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rem     <= '0;
         eff_len <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem     <= (lim < PKT_A) ? PKT_A : lim;
            eff_len <= '0;
            busy    <= 1'b1;
         end else if (busy) begin
            if (rem >= PKT_A) begin
               rem     <= rem - PKT_A;
               eff_len <= eff_len + PKT_A;
            end else begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/ts_ep3_commit_ctrl.sv
// ts_ep3_commit_ctrl - fills the EP3 isochronous IN buffer with whole TS
// packets and hands it to usb2_top through the commit/ack handshake.
//   clk, reset_n       : clock, synchronous active-low reset
//   commit_len         : requested commit size, sampled when a buffer starts
//   s_data/s_sop/s_valid/s_ready : byte stream from the ts_proxy FIFO
//   ep_in_addr/data/wren : EP3 buffer write port (1-cycle registered)
//   ep_in_ready        : buffer free for filling
//   ep_in_commit/_len/_ack : commit handshake, length stable while commit high
//   stat_commits       : number of commits (wraps)
//   stat_resyncs       : number of discarded partial packets (wraps)
module ts_ep3_commit_ctrl
   import ts_pkg::*;
#(
   parameter int unsigned PKT_LEN = TS_PKT_LEN,
   parameter int unsigned ADDR_W  = EP_ADDR_W,
   parameter int unsigned TIMEOUT = 50000
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] commit_len,
   input  logic [7:0]        s_data,
   input  logic              s_sop,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [ADDR_W-1:0] ep_in_addr,
   output logic [7:0]        ep_in_data,
   output logic              ep_in_wren,
   input  logic              ep_in_ready,
   output logic              ep_in_commit,
   output logic [ADDR_W-1:0] ep_in_commit_len,
   input  logic              ep_in_commit_ack,
   output logic [15:0]       stat_commits,
   output logic [15:0]       stat_resyncs
);
   localparam int unsigned       POS_W    = $clog2(PKT_LEN);
   localparam logic [POS_W-1:0]  LAST_POS = POS_W'(PKT_LEN - 1);
   localparam logic [ADDR_W-1:0] PKT_A    = ADDR_W'(PKT_LEN);

   logic [2:0]        state;
   logic [ADDR_W-1:0] byte_cnt;
   logic [ADDR_W-1:0] pkt_base;
   logic [POS_W-1:0]  pkt_pos;   // position of the next byte within the packet
   logic              in_pkt;
   logic [31:0]       idle_cnt;

   logic              calc_start;
   logic              calc_done;
   logic [ADDR_W-1:0] eff_len;

   logic              accept;
   logic              resync;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;

   assign s_ready          = (state == ST_FILL);
   assign accept           = s_valid && s_ready;
   assign calc_start       = (state == ST_WAIT_RDY) && ep_in_ready;
   assign ep_in_commit     = (state == ST_COMMIT);
   assign ep_in_commit_len = ep_in_commit ? byte_cnt : '0;

   // pkt_pos counts the next position, so in_pkt implies pkt_pos != 0 and
   // any s_sop inside a packet is a resync.
   always_comb begin
      resync  = accept && s_sop && in_pkt;
      wr_en   = accept && (s_sop || in_pkt);
      wr_addr = resync ? pkt_base : byte_cnt;
   end

   ts_len_align #(
      .PKT_LEN (PKT_LEN),
      .ADDR_W  (ADDR_W)
   ) u_len_align (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (calc_start),
      .lim     (commit_len),
      .done    (calc_done),
      .eff_len (eff_len)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ST_WAIT_RDY;
         byte_cnt     <= '0;
         pkt_base     <= '0;
         pkt_pos      <= '0;
         in_pkt       <= 1'b0;
         idle_cnt     <= '0;
         stat_commits <= '0;
         stat_resyncs <= '0;
      end else begin
         if (state != ST_FILL) idle_cnt <= '0;
         case (state)
            ST_WAIT_RDY: if (ep_in_ready) state <= ST_CALC;
            ST_CALC:     if (calc_done) state <= ST_FILL;
            ST_FILL: begin
               if (accept) begin
                  idle_cnt <= '0;
                  if (wr_en) begin
                     byte_cnt <= wr_addr + 1'b1;
                     if (s_sop) begin
                        in_pkt  <= 1'b1;
                        pkt_pos <= POS_W'(1);
                        if (resync) stat_resyncs <= stat_resyncs + 1'b1;
                     end else if (pkt_pos == LAST_POS) begin
                        in_pkt   <= 1'b0;
                        pkt_pos  <= '0;
                        pkt_base <= byte_cnt + 1'b1;
                        if (byte_cnt + 1'b1 == eff_len) state <= ST_COMMIT;
                     end else begin
                        pkt_pos <= pkt_pos + 1'b1;
                     end
                  end
               end else if (TIMEOUT != 0) begin
                  // Counter saturates so the flush fires as soon as a whole
                  // packet is present after a long idle stretch.
                  if (idle_cnt >= TIMEOUT - 1) begin
                     if (pkt_base >= PKT_A) begin
                        byte_cnt <= pkt_base;
                        in_pkt   <= 1'b0;
                        pkt_pos  <= '0;
                        idle_cnt <= '0;
                        state    <= ST_COMMIT;
                     end
                  end else begin
                     idle_cnt <= idle_cnt + 1'b1;
                  end
               end
            end
            ST_COMMIT: begin
               if (ep_in_commit_ack) begin
                  stat_commits <= stat_commits + 1'b1;
                  state        <= ST_WAIT_ACK_LO;
               end
            end
            ST_WAIT_ACK_LO: begin
               if (!ep_in_commit_ack) begin
                  byte_cnt <= '0;
                  pkt_base <= '0;
                  state    <= ST_WAIT_RDY;
               end
            end
            default: state <= ST_WAIT_RDY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ep_in_addr <= '0;
         ep_in_data <= '0;
         ep_in_wren <= 1'b0;
      end else begin
         ep_in_wren <= wr_en;
         if (wr_en) begin
            ep_in_addr <= wr_addr;
            ep_in_data <= s_data;
         end
      end
   end
endmodule

// File: tb/tb_ts_ep3_commit_ctrl.sv
// tb_ts_ep3_commit_ctrl - self-checking bench for ts_ep3_commit_ctrl.
// A queue-based packet model predicts writes, commits and statistics.
module tb_ts_ep3_commit_ctrl;
   localparam int unsigned PKT = 188;
   localparam int unsigned AW  = 11;
   localparam int unsigned TMO = 100;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] commit_len = 11'd1020;
   logic [7:0]    s_data = '0;
   logic          s_sop = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [AW-1:0] ep_in_addr;
   logic [7:0]    ep_in_data;
   logic          ep_in_wren;
   logic          ep_in_ready = 1'b1;
   logic          ep_in_commit;
   logic [AW-1:0] ep_in_commit_len;
   logic          ep_in_commit_ack = 1'b0;
   logic [15:0]   stat_commits;
   logic [15:0]   stat_resyncs;

   always #5 clk = ~clk;

   ts_ep3_commit_ctrl #(
      .PKT_LEN (PKT),
      .ADDR_W  (AW),
      .TIMEOUT (TMO)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .commit_len       (commit_len),
      .s_data           (s_data),
      .s_sop            (s_sop),
      .s_valid          (s_valid),
      .s_ready          (s_ready),
      .ep_in_addr       (ep_in_addr),
      .ep_in_data       (ep_in_data),
      .ep_in_wren       (ep_in_wren),
      .ep_in_ready      (ep_in_ready),
      .ep_in_commit     (ep_in_commit),
      .ep_in_commit_len (ep_in_commit_len),
      .ep_in_commit_ack (ep_in_commit_ack),
      .stat_commits     (stat_commits),
      .stat_resyncs     (stat_resyncs)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]    buf_q[$];    // whole packets in the current buffer
   logic [7:0]    part_q[$];   // packet under construction
   int            m_eff = 0;
   int            m_len = 0;
   int            idle = 0;
   bit            pending = 0;
   logic [15:0]   m_commits = '0;
   logic [15:0]   m_resyncs = '0;
   bit            exp_wren = 0;
   int            exp_addr = 0;
   logic [7:0]    exp_data = '0;
   bit            started = 0;

   // observation of the DUT write port / commit
   logic [7:0]    dut_mem[2048];
   bit            prev_commit = 0;
   int            hi_cnt = 0, last_hi = 0, last_len = 0;
   int            wr_cnt = 0, first_wr_addr = -1, first_wr_data = -1, jump_addr = -1;
   int            prev_wr_addr = 0;
   int            nerr;
   int            lim;

   int            ack_dly = 3;
   bit            ack_en  = 1;

   always @(negedge clk) begin
      if (started) begin
         check("wren", ep_in_wren, exp_wren);
         if (exp_wren) begin
            check("addr", ep_in_addr, exp_addr);
            check("data", ep_in_data, exp_data);
         end
         check("commit", ep_in_commit, pending);
         check("commit_len", ep_in_commit_len, pending ? m_len : 0);
         if (pending) check("s_ready_hold", s_ready, 0);
         check("stat_commits", stat_commits, m_commits);
         check("stat_resyncs", stat_resyncs, m_resyncs);

         if (ep_in_wren) begin
            dut_mem[ep_in_addr] = ep_in_data;
            if (wr_cnt == 0) begin
               first_wr_addr = ep_in_addr;
               first_wr_data = ep_in_data;
            end else if (int'(ep_in_addr) != prev_wr_addr + 1) begin
               jump_addr = ep_in_addr;
            end
            prev_wr_addr = ep_in_addr;
            wr_cnt++;
         end
         if (ep_in_commit && !prev_commit) begin
            last_len = ep_in_commit_len;
            nerr = 0;
            foreach (buf_q[i]) if (dut_mem[i] !== buf_q[i]) nerr++;
            check("buffer_contents", nerr, 0);
            hi_cnt = 0;
         end
         if (ep_in_commit) hi_cnt++;
         else if (prev_commit) last_hi = hi_cnt;
         prev_commit = ep_in_commit;
      end

      // model step for the coming rising edge
      exp_wren = 0;
      if (!reset_n) begin
         buf_q.delete();
         part_q.delete();
         pending   = 0;
         m_commits = '0;
         m_resyncs = '0;
         idle      = 0;
         wr_cnt    = 0;
         jump_addr = -1;
         prev_commit = 0;
         for (int i = 0; i < 2048; i++) dut_mem[i] = 'x;
         started = 1;
      end else if (pending) begin
         if (ep_in_commit_ack) begin
            pending = 0;
            m_commits++;
            buf_q.delete();
            for (int i = 0; i < 2048; i++) dut_mem[i] = 'x;
         end
      end else if (s_valid && s_ready) begin
         idle = 0;
         if (buf_q.size() == 0 && part_q.size() == 0) begin
            lim   = (int'(commit_len) < PKT) ? PKT : int'(commit_len);
            m_eff = (lim / PKT) * PKT;
         end
         if (s_sop) begin
            if (part_q.size() != 0) m_resyncs++;
            part_q.delete();
            part_q.push_back(s_data);
            exp_wren = 1;
            exp_addr = buf_q.size();
            exp_data = s_data;
         end else if (part_q.size() != 0) begin
            part_q.push_back(s_data);
            exp_wren = 1;
            exp_addr = buf_q.size() + part_q.size() - 1;
            exp_data = s_data;
            if (part_q.size() == PKT) begin
               foreach (part_q[i]) buf_q.push_back(part_q[i]);
               part_q.delete();
               if (buf_q.size() == m_eff) begin
                  pending = 1;
                  m_len   = m_eff;
               end
            end
         end
      end else if (s_ready) begin
         idle++;
         if (idle >= TMO && buf_q.size() >= PKT) begin
            part_q.delete();
            pending = 1;
            m_len   = buf_q.size();
            idle    = 0;
         end
      end else begin
         idle = 0;
      end
   end

   // ---------------- commit acknowledge responder ----------------
   initial begin
      int n;
      forever begin
         @(negedge clk);
         if (ep_in_commit && ack_en && !ep_in_commit_ack) begin
            repeat (ack_dly - 1) @(posedge clk);
            #1 ep_in_commit_ack = 1'b1;
            n = 0;
            while (ep_in_commit && n < 20) begin
               @(negedge clk);
               n++;
            end
            if (ep_in_commit) check("commit_drop", ep_in_commit, 0);
            @(posedge clk);
            #1 ep_in_commit_ack = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic send_byte(input logic [7:0] d, input bit sop);
      bit ok;
      int n;
      n = 0;
      s_data  = d;
      s_sop   = sop;
      s_valid = 1'b1;
      do begin
         @(negedge clk);
         ok = s_ready;
         @(posedge clk);
         n++;
      end while (!ok && n < 3000);
      if (!ok) check("byte_accept", ok, 1);
      #1;
      s_valid = 1'b0;
      s_sop   = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_pkt(input int n);
      for (int i = 0; i < n; i++)
         send_byte(i == 0 ? 8'h47 : 8'($urandom), i == 0);
   endtask

   task automatic wait_commits(input int target, input int budget);
      int n;
      n = 0;
      while (int'(m_commits) < target && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("wait_commits", m_commits, target);
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [AW-1:0] cl);
      @(posedge clk);
      #1 reset_n = 1'b0;
      commit_len = cl;
      ack_dly = 3;
      ack_en  = 1;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   initial begin
      int n;
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_s_ready", s_ready, 0);
      check("rst_commit", ep_in_commit, 0);
      check("rst_commit_len", ep_in_commit_len, 0);
      check("rst_wren", ep_in_wren, 0);
      check("rst_addr", ep_in_addr, 0);
      check("rst_stats", {stat_commits, stat_resyncs}, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // ten back-to-back packets into 940-byte buffers
      for (int p = 0; p < 10; p++) send_pkt(PKT);
      wait_commits(2, 2000);
      check("t1_commits", stat_commits, 2);
      check("t1_len", last_len, 940);

      // short commit_len rounds up to one packet, long ack delay
      do_reset(11'd100);
      ack_dly = 40;
      send_pkt(PKT);
      wait_commits(1, 400);
      check("t2_len", last_len, 188);
      check("t2_hi_cycles", last_hi, 40);

      // junk before the first sync byte is dropped
      do_reset(11'd1020);
      for (int i = 0; i < 50; i++) send_byte(8'($urandom_range(0, 70)), 0);
      check("t3_no_writes", wr_cnt, 0);
      for (int p = 0; p < 5; p++) send_pkt(PKT);
      wait_commits(1, 2000);
      check("t3_first_addr", first_wr_addr, 0);
      check("t3_first_data", first_wr_data, 8'h47);
      check("t3_len", last_len, 940);

      // sync byte at position 90 of the third packet
      do_reset(11'd1020);
      send_pkt(PKT);
      send_pkt(PKT);
      send_pkt(90);
      for (int p = 0; p < 3; p++) send_pkt(PKT);
      wait_commits(1, 2000);
      check("t4_resync_addr", jump_addr, 376);
      check("t4_resyncs", stat_resyncs, 1);
      check("t4_len", last_len, 940);

      // idle flush of 2.5 packets
      do_reset(11'd1020);
      send_pkt(PKT);
      send_pkt(PKT);
      send_pkt(94);
      wait_commits(1, 600);
      check("t5_len", last_len, 376);

      // randomized streams with random commit_len
      for (int r = 0; r < 4; r++) begin
         do_reset(11'($urandom_range(1, 2047)));
         ack_dly = $urandom_range(1, 8);
         for (int e = 0; e < 200 && m_commits == 0; e++) begin
            n = $urandom_range(0, 7);
            if (n == 0) send_byte(8'($urandom), 0);
            else if (n == 1) send_pkt($urandom_range(1, PKT - 1));
            else send_pkt(PKT);
         end
         wait_commits(1, 600);
      end

      // reset while a commit is pending
      do_reset(11'd100);
      ack_en = 0;
      send_pkt(20);
      send_pkt(PKT);
      n = 0;
      while (!ep_in_commit && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("t6_commit_seen", ep_in_commit, 1);
      check("t6_resyncs", stat_resyncs, 1);
      @(posedge clk);
      #1 reset_n = 1'b0;
      ep_in_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("t6_commit_dropped", ep_in_commit, 0);
      check("t6_stats", {stat_commits, stat_resyncs}, 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("t6_wait_rdy", s_ready, 0);
      ep_in_ready = 1'b1;
      repeat (5) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
